// File: rtl/uart_pkg.sv
// uart_pkg: shared parity constants, receiver FSM encoding and baud divisor helper
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK} state_t;
  function automatic int calc_div(real clk_freq, int baud, int os);
    return $rtoi(clk_freq / (real'(baud) * real'(os)) + 0.5);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick generator, realignable on a start edge
module uart_baud_tick import uart_pkg::*; #(
  parameter real CLK_FREQ = 100_000_000.0,
  parameter int BAUD_RATE = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart,
  output logic tick
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW = $clog2(DIV + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // tick on the last count of each period; restart realigns the phase to the start edge
  always_comb begin
    tick = cnt_q == CW'(DIV - 1);
    cnt_d = (restart || tick) ? '0 : cnt_q + 1'b1;
  end
  // divider counter register
  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with parity/frame checks and a valid/ready output
module uart_rx_param import uart_pkg::*; #(
  parameter real CLK_FREQ = 100_000_000.0,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY = PARITY_NONE,
  parameter int STOP_BITS = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 overrun
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] T_A = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] T_C = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] T_E = SW'(OVERSAMPLE - 1);
  state_t state_q, state_d;
  logic [2:0] sync_q, sync_d;
  logic [SW-1:0] sc_q, sc_d;
  logic [3:0] bc_q, bc_d;
  logic [1:0] smp_q, smp_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic pe_c_q, pe_c_d, fe_c_q, fe_c_d, done_q, done_d;
  logic valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, ovr_q, ovr_d;
  logic rx_s, start_edge, tick, maj, decide, bit_end, fe_now, load;
  uart_baud_tick #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk(clk),
    .rstn(rstn),
    .restart(state_q == S_IDLE && start_edge),
    .tick(tick)
  );
  // registers: two-flop synchroniser plus edge history, FSM, datapath, output holding
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      sync_q <= '1;
      sc_q <= '0;
      bc_q <= '0;
      smp_q <= '0;
      sh_q <= '0;
      pe_c_q <= 1'b0;
      fe_c_q <= 1'b0;
      done_q <= 1'b0;
      valid_q <= 1'b0;
      data_q <= '0;
      pe_q <= 1'b0;
      fe_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      sc_q <= sc_d;
      bc_q <= bc_d;
      smp_q <= smp_d;
      sh_q <= sh_d;
      pe_c_q <= pe_c_d;
      fe_c_q <= fe_c_d;
      done_q <= done_d;
      valid_q <= valid_d;
      data_q <= data_d;
      pe_q <= pe_d;
      fe_q <= fe_d;
      ovr_q <= ovr_d;
    end
  end
  // next state: majority-vote sampling around mid-bit, shift data, build error candidates
  always_comb begin
    sync_d = {sync_q[1:0], rxd};
    rx_s = sync_q[1];
    start_edge = sync_q[2] & ~rx_s;
    maj = (smp_q[0] & smp_q[1]) | (rx_s & (smp_q[0] | smp_q[1]));
    decide = tick && sc_q == T_C;
    bit_end = tick && sc_q == T_E;
    fe_now = (bc_q == '0) ? ~maj : fe_c_q;
    state_d = state_q;
    sc_d = !tick ? sc_q : (sc_q == T_E ? '0 : sc_q + 1'b1);
    smp_d = (tick && sc_q >= T_A && sc_q < T_C) ? {smp_q[0], rx_s} : smp_q;
    bc_d = bc_q;
    sh_d = sh_q;
    pe_c_d = pe_c_q;
    fe_c_d = fe_c_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (start_edge) begin
        state_d = S_START;
        sc_d = '0;
        bc_d = '0;
        pe_c_d = 1'b0;
        fe_c_d = 1'b0;
      end
      S_START: state_d = (decide && maj) ? S_IDLE : (bit_end ? S_DATA : S_START);
      S_DATA: begin
        if (decide) sh_d = {maj, sh_q[DATA_BITS-1:1]};
        if (bit_end) begin
          bc_d = (bc_q == 4'(DATA_BITS - 1)) ? '0 : bc_q + 1'b1;
          if (bc_q == 4'(DATA_BITS - 1)) state_d = (PARITY != PARITY_NONE) ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (decide) pe_c_d = maj ^ (^sh_q) ^ (PARITY == PARITY_ODD);
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: if (decide) begin
        fe_c_d = fe_now;
        bc_d = bc_q + 1'b1;
        if (bc_q == 4'(STOP_BITS - 1)) begin
          done_d = 1'b1;
          state_d = fe_now ? S_BREAK : S_IDLE;
        end
      end
      S_BREAK: if (rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // outputs: deliver into holding registers, drop and flag overrun while a word is unaccepted
  always_comb begin
    rx_busy = state_q != S_IDLE;
    load = done_q & (~valid_q | rx_ready);
    valid_d = done_q | (valid_q & ~rx_ready);
    data_d = load ? sh_q : data_q;
    pe_d = load ? pe_c_q : pe_q;
    fe_d = load ? fe_c_q : fe_q;
    ovr_d = (done_q & valid_q & ~rx_ready) | (ovr_q & ~(valid_q & rx_ready));
    rx_data = data_q;
    rx_valid = valid_q;
    parity_error = pe_q;
    frame_error = fe_q;
    overrun = ovr_q;
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: table-driven frame checks plus break, glitch, overrun and reset sequences
module tb_uart_rx_param;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rdy_f = 1'b1;
  logic [2:0] line = 3'b111;
  logic [7:0] data_f, data_p, data_d;
  logic [2:0] valid, busy, pe, fe, ovr;
  int errors = 0;
  int checks = 0;
  int cnt [3];
  logic [7:0] ld [3];
  logic lpe [3];
  logic lfe [3];
  int c0;
  typedef struct {
    int w;
    logic [7:0] d;
    logic pb;
    logic sb;
    logic [7:0] ed;
    logic epe;
    logic efe;
  } vec_t;
  vec_t vt [8];

  always #5 clk = ~clk;

  uart_rx_param #(.BAUD_RATE(1_562_500)) dut (
    .clk(clk), .rstn(rstn), .rxd(line[0]), .rx_data(data_f), .rx_valid(valid[0]),
    .rx_ready(rdy_f), .rx_busy(busy[0]), .parity_error(pe[0]), .frame_error(fe[0]), .overrun(ovr[0]));
  uart_rx_param #(.BAUD_RATE(1_562_500), .PARITY(2)) dut_p (
    .clk(clk), .rstn(rstn), .rxd(line[1]), .rx_data(data_p), .rx_valid(valid[1]),
    .rx_ready(1'b1), .rx_busy(busy[1]), .parity_error(pe[1]), .frame_error(fe[1]), .overrun(ovr[1]));
  uart_rx_param dut_d (
    .clk(clk), .rstn(rstn), .rxd(line[2]), .rx_data(data_d), .rx_valid(valid[2]),
    .rx_ready(1'b1), .rx_busy(busy[2]), .parity_error(pe[2]), .frame_error(fe[2]), .overrun(ovr[2]));

  always @(negedge clk) begin
    if (valid[0] && rdy_f) begin cnt[0]++; ld[0] = data_f; lpe[0] = pe[0]; lfe[0] = fe[0]; end
    if (valid[1]) begin cnt[1]++; ld[1] = data_p; lpe[1] = pe[1]; lfe[1] = fe[1]; end
    if (valid[2]) begin cnt[2]++; ld[2] = data_d; lpe[2] = pe[2]; lfe[2] = fe[2]; end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic hold(input int w, input logic v, input int n);
    line[w] = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int w, input logic [7:0] d, input logic pb, input logic sb);
    int bt;
    bt = (w == 2) ? 864 : 64;
    hold(w, 1'b0, bt);
    for (int i = 0; i < 8; i++) hold(w, d[i], bt);
    if (w == 1) hold(w, pb, bt);
    hold(w, sb, bt);
    hold(w, 1'b1, 2 * bt);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{2, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vt[2] = '{0, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
    vt[3] = '{1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    vt[4] = '{1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    vt[5] = '{1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vt[6] = '{0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
    vt[7] = '{1, 8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_data", 32'(data_f), 32'h0);
    chk("rst_flags", 32'({pe, fe, ovr}), 32'h0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      c0 = cnt[vt[i].w];
      send(vt[i].w, vt[i].d, vt[i].pb, vt[i].sb);
      chk($sformatf("v%0d_words", i), 32'(cnt[vt[i].w]), 32'(c0 + 1));
      chk($sformatf("v%0d_data", i), 32'(ld[vt[i].w]), 32'(vt[i].ed));
      chk($sformatf("v%0d_pe", i), 32'(lpe[vt[i].w]), 32'(vt[i].epe));
      chk($sformatf("v%0d_fe", i), 32'(lfe[vt[i].w]), 32'(vt[i].efe));
      chk($sformatf("v%0d_busy", i), 32'(busy[vt[i].w]), 32'h0);
    end
    c0 = cnt[0];
    hold(0, 1'b0, 20 * 64);
    chk("brk_words", 32'(cnt[0]), 32'(c0 + 1));
    chk("brk_data", 32'(ld[0]), 32'h00);
    chk("brk_fe", 32'(lfe[0]), 32'h1);
    chk("brk_busy", 32'(busy[0]), 32'h1);
    hold(0, 1'b1, 2 * 64);
    chk("brk_nomore", 32'(cnt[0]), 32'(c0 + 1));
    chk("brk_idle", 32'(busy[0]), 32'h0);
    send(0, 8'h5A, 1'b0, 1'b1);
    chk("brk_next_words", 32'(cnt[0]), 32'(c0 + 2));
    chk("brk_next_data", 32'(ld[0]), 32'h5A);
    chk("brk_next_flags", 32'({lpe[0], lfe[0]}), 32'h0);
    c0 = cnt[0];
    hold(0, 1'b0, 12);
    hold(0, 1'b1, 2 * 64);
    chk("glitch_words", 32'(cnt[0]), 32'(c0));
    chk("glitch_busy", 32'(busy[0]), 32'h0);
    send(0, 8'h3C, 1'b0, 1'b1);
    chk("glitch_next_words", 32'(cnt[0]), 32'(c0 + 1));
    chk("glitch_next_data", 32'(ld[0]), 32'h3C);
    rdy_f = 1'b0;
    c0 = cnt[0];
    send(0, 8'h11, 1'b0, 1'b1);
    chk("ovr_first_ovr", 32'(ovr[0]), 32'h0);
    send(0, 8'h22, 1'b0, 1'b1);
    chk("ovr_valid", 32'(valid[0]), 32'h1);
    chk("ovr_held", 32'(data_f), 32'h11);
    chk("ovr_flag", 32'(ovr[0]), 32'h1);
    @(posedge clk);
    #2 rdy_f = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovr_hs_words", 32'(cnt[0]), 32'(c0 + 1));
    chk("ovr_hs_data", 32'(ld[0]), 32'h11);
    chk("ovr_hs_valid", 32'(valid[0]), 32'h0);
    chk("ovr_cleared", 32'(ovr[0]), 32'h0);
    c0 = cnt[0];
    hold(0, 1'b0, 64);
    for (int i = 0; i < 3; i++) hold(0, 1'b1, 64);
    chk("mid_busy", 32'(busy[0]), 32'h1);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("mrst_busy", 32'(busy[0]), 32'h0);
    chk("mrst_valid", 32'(valid[0]), 32'h0);
    chk("mrst_data", 32'(data_f), 32'h0);
    chk("mrst_flags", 32'({pe[0], fe[0], ovr[0]}), 32'h0);
    rstn = 1'b1;
    hold(0, 1'b1, 8 * 64);
    chk("mrst_nodeliver", 32'(cnt[0]), 32'(c0));
    send(0, 8'h81, 1'b0, 1'b1);
    chk("mrst_next_words", 32'(cnt[0]), 32'(c0 + 1));
    chk("mrst_next_data", 32'(ld[0]), 32'h81);
    chk("mrst_next_flags", 32'({lpe[0], lfe[0]}), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
